// File: rtl/router_pkg.sv
// Shared router definitions: port indices, allocator state encoding,
// and the round-robin pointer helper used by the output allocators.
package router_pkg;

    localparam int NUM_PORTS  = 5;
    localparam int PTR_W      = $clog2(NUM_PORTS);

    localparam int PORT_NORTH = 0;
    localparam int PORT_EAST  = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } alloc_state_t;

    // Index one past the set bit of a one-hot owner, wrapping.
    function automatic logic [PTR_W-1:0] next_ptr(
        input logic [NUM_PORTS-1:0] onehot
    );
        logic [PTR_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (onehot[i]) begin
                p = PTR_W'((i + 1) % NUM_PORTS);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr,
// wrapping, returned as a one-hot grant.
import router_pkg::*;

module rr_arbiter #(
    parameter int N     = NUM_PORTS,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_alloc.sv
// Per-output-port allocator: round-robin packet-level lock with
// downstream credit gating of flit transfers.
import router_pkg::*;

module output_port_alloc #(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 credit_return_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic                 xfer_o,
    output logic [CNT_W-1:0]     credit_cnt_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    alloc_state_t         state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 err_q;
    logic [NUM_PORTS-1:0] winner;
    logic                 own_req;
    logic                 own_tail;
    logic                 xfer;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (winner)
    );

    assign own_req  = |(req_i & grant_q);
    assign own_tail = |(tail_i & grant_q);
    assign xfer     = (state_q == LOCKED) && own_req
                      && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer && own_tail) begin
                    grant_d = '0;
                    ptr_d   = next_ptr(grant_q);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Simultaneous xfer and return cancel; a return into a full
    // buffer is a protocol violation and is latched until reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= FULL;
            err_q <= 1'b0;
        end else begin
            unique case (1'b1)
                (xfer && !credit_return_i): begin
                    cnt_q <= cnt_q - 1'b1;
                end
                (!xfer && credit_return_i): begin
                    if (cnt_q == FULL) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign xfer_o       = xfer;
    assign credit_cnt_o = cnt_q;
    assign busy_o       = (state_q == LOCKED);
    assign err_o        = err_q;

endmodule
